// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback stage behind the ALU.
// Commits ALU flags into the architectural status register, queues
// register-file writes in a small circular FIFO drained over valid/ready,
// applies backpressure to execute and counts retired instructions.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready. On the execute
// side ex_ready comes from the registered FIFO count only, so a same-cycle pop
// never raises it. flush overrides both handshakes for the cycle.
module ex_wb_stage #(
   parameter int          DATA_W   = 32,
   parameter int          REG_AW   = 4,
   parameter int          DEPTH    = 2,
   parameter logic [3:0]  FLAG_RST = 4'b0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [3:0]        ex_flags,
   input  logic              ex_s,
   input  logic              ex_cond_pass,
   input  logic              ex_we,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              flush,
   output logic [3:0]        status_flags,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       retired
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

   logic [REG_AW-1:0] r_mem_rd   [DEPTH];
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [3:0]        r_flags;
   logic [31:0]       r_retired;

   logic w_accept;
   logic w_commit;
   logic w_push;
   logic w_pop;

   assign ex_ready     = (r_count != C_FULL);
   assign wb_valid     = (r_count != '0);
   assign wb_rd        = r_mem_rd[r_rd_ptr];
   assign wb_data      = r_mem_data[r_rd_ptr];
   assign status_flags = r_flags;
   assign retired      = r_retired;

   // Transfer qualification; flush squashes both sides of the stage.
   always_comb begin
      w_accept = ex_valid & ex_ready & ~flush;
      w_commit = w_accept & ex_cond_pass;
      w_push   = w_commit & ex_we;
      w_pop    = wb_valid & wb_ready & ~flush;
   end

   // Architectural state: flags and retire count survive a flush.
   // The counter adds the commit bit every cycle so it is always rewritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags   <= FLAG_RST;
         r_retired <= '0;
      end else begin
         if (w_commit && ex_s) begin
            r_flags <= ex_flags;
         end
         r_retired <= r_retired + {31'd0, w_commit};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // FIFO storage; cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_rd[i]   <= '0;
            r_mem_data[i] <= '0;
         end
      end else if (w_push) begin
         r_mem_rd[r_wr_ptr]   <= ex_rd;
         r_mem_data[r_wr_ptr] <= ex_result;
      end
   end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Testbench for ex_wb_stage: vector table, directed corner sequences and a
// random phase, with a write-queue scoreboard checked at the FIFO output.
module tb_ex_wb_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 4;
   localparam int DEPTH  = 2;

   logic              clk;
   logic              rst_n;
   logic              ex_valid;
   logic              ex_ready;
   logic [DATA_W-1:0] ex_result;
   logic [3:0]        ex_flags;
   logic              ex_s;
   logic              ex_cond_pass;
   logic              ex_we;
   logic [REG_AW-1:0] ex_rd;
   logic              flush;
   logic [3:0]        status_flags;
   logic              wb_valid;
   logic              wb_ready;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic [31:0]       retired;

   ex_wb_stage #(
      .DATA_W   (DATA_W),
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .FLAG_RST (4'b0000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_result    (ex_result),
      .ex_flags     (ex_flags),
      .ex_s         (ex_s),
      .ex_cond_pass (ex_cond_pass),
      .ex_we        (ex_we),
      .ex_rd        (ex_rd),
      .flush        (flush),
      .status_flags (status_flags),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .retired      (retired)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [REG_AW+DATA_W-1:0] exp_q[$];
   int          m_count   = 0;
   logic [3:0]  m_flags   = 4'b0000;
   logic [31:0] m_retired = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Output monitor: a pop compares the head against the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && wb_valid && wb_ready && !flush) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wb_unexpected actual=pop required=no_pop at %0t", $time);
         end else begin
            logic [REG_AW+DATA_W-1:0] e;
            e = exp_q.pop_front();
            check("wb_rd", {60'd0, wb_rd}, {60'd0, e[REG_AW+DATA_W-1:DATA_W]});
            check("wb_data", {32'd0, wb_data}, {32'd0, e[DATA_W-1:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_ex(input logic v, input logic [31:0] res, input logic [3:0] fl,
                         input logic s, input logic cp, input logic we, input logic [3:0] rd);
      ex_valid     = v;
      ex_result    = res;
      ex_flags     = fl;
      ex_s         = s;
      ex_cond_pass = cp;
      ex_we        = we;
      ex_rd        = rd;
   endtask

   // One clock with the currently driven inputs; model updated, results checked.
   task automatic tick();
      logic acc, cmt, psh, pp;
      check("ex_ready", {63'd0, ex_ready}, {63'd0, (m_count != DEPTH)});
      check("wb_valid", {63'd0, wb_valid}, {63'd0, (m_count != 0)});
      acc = ex_valid && (m_count != DEPTH) && !flush;
      cmt = acc && ex_cond_pass;
      psh = cmt && ex_we;
      pp  = (m_count != 0) && wb_ready && !flush;
      if (flush) begin
         m_count = 0;
         exp_q.delete();
      end else begin
         if (cmt && ex_s) m_flags = ex_flags;
         if (cmt) m_retired = m_retired + 32'd1;
         if (psh) exp_q.push_back({ex_rd, ex_result});
         m_count = m_count + int'(psh) - int'(pp);
      end
      @(posedge clk);
      #1;
      check("status_flags", {60'd0, status_flags}, {60'd0, m_flags});
      check("retired", {32'd0, retired}, {32'd0, m_retired});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        v;
      logic [31:0] res;
      logic [3:0]  fl;
      logic        s;
      logic        cp;
      logic        we;
      logic [3:0]  rd;
      logic [3:0]  exp_fl;
      logic        exp_wbv;
      logic [31:0] exp_inc;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [31:0] base;

      // add with S, compare, cond fail, no-S write, S write, idle, compare-only
      tbl[0] = '{1'b1, 32'd16,         4'b0000, 1'b1, 1'b1, 1'b1, 4'd3,  4'b0000, 1'b1, 32'd1};
      tbl[1] = '{1'b1, 32'd0,          4'b0100, 1'b1, 1'b1, 1'b0, 4'd5,  4'b0100, 1'b0, 32'd1};
      tbl[2] = '{1'b1, 32'd99,         4'b1000, 1'b1, 1'b0, 1'b1, 4'd7,  4'b0100, 1'b0, 32'd0};
      tbl[3] = '{1'b1, 32'hDEADBEEF,   4'b1111, 1'b0, 1'b1, 1'b1, 4'd9,  4'b0100, 1'b1, 32'd1};
      tbl[4] = '{1'b1, 32'h12345678,   4'b1010, 1'b1, 1'b1, 1'b1, 4'd15, 4'b1010, 1'b1, 32'd1};
      tbl[5] = '{1'b0, 32'd1,          4'b0001, 1'b1, 1'b1, 1'b1, 4'd1,  4'b1010, 1'b0, 32'd0};
      tbl[6] = '{1'b1, 32'd0,          4'b0011, 1'b1, 1'b1, 1'b0, 4'd2,  4'b0011, 1'b0, 32'd1};

      rst_n    = 1'b0;
      flush    = 1'b0;
      wb_ready = 1'b0;
      set_ex(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);

      // reset values
      #3;
      check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
      check("rst_flags", {60'd0, status_flags}, 64'd0);
      check("rst_retired", {32'd0, retired}, 64'd0);
      check("rst_wb_rd", {60'd0, wb_rd}, 64'd0);
      check("rst_wb_data", {32'd0, wb_data}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // table: wb_ready held high, one instruction per cycle
      wb_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         base = m_retired;
         set_ex(tbl[i].v, tbl[i].res, tbl[i].fl, tbl[i].s, tbl[i].cp, tbl[i].we, tbl[i].rd);
         tick();
         check($sformatf("tbl%0d_flags", i), {60'd0, status_flags}, {60'd0, tbl[i].exp_fl});
         check($sformatf("tbl%0d_wbv", i), {63'd0, wb_valid}, {63'd0, tbl[i].exp_wbv});
         check($sformatf("tbl%0d_retired", i), {32'd0, retired}, {32'd0, base + tbl[i].exp_inc});
      end
      set_ex(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      tick();

      // backpressure: 5 and 7 fill the FIFO, 33 is held until a slot frees
      wb_ready = 1'b0;
      set_ex(1'b1, 32'd5, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1);
      tick();
      set_ex(1'b1, 32'd7, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2);
      tick();
      check("bp_full_ex_ready", {63'd0, ex_ready}, 64'd0);
      set_ex(1'b1, 32'd33, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3);
      base = m_retired;
      for (int i = 0; i < 3; i++) tick();
      check("bp_held_retired", {32'd0, retired}, {32'd0, base});
      wb_ready = 1'b1;
      tick();
      check("bp_rise_after_pop", {63'd0, ex_ready}, 64'd1);
      tick();
      set_ex(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      tick();
      check("bp_drained", {63'd0, wb_valid}, 64'd0);

      // retire counter wrap
      force dut.r_retired = 32'hFFFF_FFFF;
      m_retired = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.r_retired;
      check("wrap_preload", {32'd0, retired}, 64'h0000_0000_FFFF_FFFF);
      set_ex(1'b1, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
      tick();
      check("wrap_zero", {32'd0, retired}, 64'd0);

      // flush with two queued entries and an incoming instruction
      wb_ready = 1'b0;
      set_ex(1'b1, 32'hA1, 4'b0110, 1'b1, 1'b1, 1'b1, 4'd4);
      tick();
      set_ex(1'b1, 32'hA2, 4'b0110, 1'b1, 1'b1, 1'b1, 4'd5);
      tick();
      set_ex(1'b1, 32'hA3, 4'b1001, 1'b1, 1'b1, 1'b1, 4'd6);
      flush    = 1'b1;
      wb_ready = 1'b1;
      base = m_retired;
      tick();
      check("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("flush_ex_ready", {63'd0, ex_ready}, 64'd1);
      check("flush_flags", {60'd0, status_flags}, 64'd6);
      check("flush_retired", {32'd0, retired}, {32'd0, base});
      flush = 1'b0;
      set_ex(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();

      // asynchronous reset with two queued entries
      wb_ready = 1'b0;
      set_ex(1'b1, 32'hB1, 4'b1100, 1'b1, 1'b1, 1'b1, 4'd7);
      tick();
      set_ex(1'b1, 32'hB2, 4'b1100, 1'b1, 1'b1, 1'b1, 4'd8);
      tick();
      set_ex(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      rst_n = 1'b0;
      m_count   = 0;
      m_flags   = 4'b0000;
      m_retired = 32'd0;
      exp_q.delete();
      #1;
      check("amid_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("amid_ex_ready", {63'd0, ex_ready}, 64'd1);
      check("amid_flags", {60'd0, status_flags}, 64'd0);
      check("amid_retired", {32'd0, retired}, 64'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      wb_ready = 1'b1;
      tick();
      tick();

      // random phase
      for (int i = 0; i < 60; i++) begin
         set_ex(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         wb_ready = 1'($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         tick();
      end
      flush    = 1'b0;
      wb_ready = 1'b1;
      set_ex(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      tick();
      tick();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
